// File: rtl/cmd_ram_v2.sv
//============================================================================
// Module   : cmd_ram_v2
// Purpose  : Command-driven single-port RAM. A 2-bit opcode on each valid
//            input word selects: set write address, write data, set read
//            address, or read data. Read data comes out through a one-entry
//            valid/ready output register. A read that arrives while that
//            register is full and not being drained is dropped, and this
//            sets a sticky error flag.
// Ports    : clk      - clock, rising edge
//            rst      - synchronous active-high reset
//            din      - {opcode[1:0], payload[DATA_W-1:0]}
//            rx_valid - din carries a command this cycle
//            dout     - registered read data
//            tx_valid - dout holds unconsumed read data
//            tx_ready - consumer takes dout this cycle
//            err      - sticky: a read-data command was dropped
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module cmd_ram_v2 #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int AUTO_INC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W+1:0] din,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              err
);

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic [1:0]        opcode;
  logic [DATA_W-1:0] payload;
  logic [ADDR_W-1:0] addr_pl;
  logic              cmd_wr_addr;
  logic              cmd_wr_data;
  logic              cmd_rd_addr;
  logic              cmd_rd_data;
  logic              rd_accept;
  logic              rd_drop;
  logic              wr_en;

  assign opcode  = din[DATA_W+1:DATA_W];
  assign payload = din[DATA_W-1:0];

  // Address payload: low ADDR_W bits, or zero-extended when the data word is
  // narrower than the address.
  generate
    if (ADDR_W <= DATA_W) begin : g_addr_trunc
      assign addr_pl = payload[ADDR_W-1:0];
    end else begin : g_addr_ext
      assign addr_pl = {{(ADDR_W-DATA_W){1'b0}}, payload};
    end
  endgenerate

  assign cmd_wr_addr = rx_valid && (opcode == OP_WR_ADDR);
  assign cmd_wr_data = rx_valid && (opcode == OP_WR_DATA);
  assign cmd_rd_addr = rx_valid && (opcode == OP_RD_ADDR);
  assign cmd_rd_data = rx_valid && (opcode == OP_RD_DATA);

  // A read fits if the output register is empty or is being drained now.
  assign rd_accept = cmd_rd_data && ((state == EMPTY) || tx_ready);
  assign rd_drop   = cmd_rd_data && (state == FULL) && !tx_ready;

  // Reset suppresses the write so that reset takes priority over commands,
  // but it never clears the array itself.
  assign wr_en = cmd_wr_data && !rst;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= payload;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      wr_addr <= '0;
      rd_addr <= '0;
      dout    <= '0;
      err     <= 1'b0;
    end else begin
      if (cmd_wr_addr) begin
        wr_addr <= addr_pl;
      end else if (cmd_wr_data && (AUTO_INC != 0)) begin
        wr_addr <= wr_addr + ADDR_W'(1);
      end

      if (cmd_rd_addr) begin
        rd_addr <= addr_pl;
      end else if (rd_accept && (AUTO_INC != 0)) begin
        rd_addr <= rd_addr + ADDR_W'(1);
      end

      if (rd_drop) begin
        err <= 1'b1;
      end

      // The memory write above lands on the previous edge, so a read one
      // cycle after a write to the same address sees the new value.
      case (state)
        EMPTY: begin
          if (rd_accept) begin
            dout  <= mem[rd_addr];
            state <= FULL;
          end
        end
        FULL: begin
          if (rd_accept) begin
            dout  <= mem[rd_addr];
            state <= FULL;
          end else if (tx_ready) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign tx_valid = (state == FULL);

endmodule

`default_nettype wire

// File: tb/tb_cmd_ram_v2.sv
//============================================================================
// Module   : tb_cmd_ram_v2
// Purpose  : Directed, table-driven bench for cmd_ram_v2. Instance u_dut
//            uses the default 8/8 configuration with auto-increment;
//            u_dut16 uses DATA_W=16, ADDR_W=4 with static addresses.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_cmd_ram_v2;

  logic        clk;
  logic        rst;
  logic [9:0]  din;
  logic        rx_valid;
  logic [7:0]  dout;
  logic        tx_valid;
  logic        tx_ready;
  logic        err;

  logic [17:0] din2;
  logic        rx_valid2;
  logic [15:0] dout2;
  logic        tx_valid2;
  logic        tx_ready2;
  logic        err2;

  int n_vec;
  int n_bad;

  cmd_ram_v2 #(.ADDR_W(8), .DATA_W(8), .AUTO_INC(1)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .rx_valid (rx_valid),
    .dout     (dout),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .err      (err)
  );

  cmd_ram_v2 #(.ADDR_W(4), .DATA_W(16), .AUTO_INC(0)) u_dut16 (
    .clk      (clk),
    .rst      (rst),
    .din      (din2),
    .rx_valid (rx_valid2),
    .dout     (dout2),
    .tx_valid (tx_valid2),
    .tx_ready (tx_ready2),
    .err      (err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       rv;
    logic [1:0] op;
    logic [7:0] pl;
    logic       rdy;
    logic       ev;   // expected tx_valid
    logic       cd;   // compare dout on this vector
    logic [7:0] ed;   // expected dout
    logic       ee;   // expected err
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic rv, input logic [1:0] op,
                              input logic [7:0] pl, input logic rdy, input logic ev,
                              input logic cd, input logic [7:0] ed, input logic ee);
    vec_t v;
    v.rst = r;  v.rv = rv;  v.op = op;  v.pl = pl;  v.rdy = rdy;
    v.ev  = ev; v.cd = cd;  v.ed = ed;  v.ee = ee;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step2(input logic rv, input logic [1:0] op, input logic [15:0] pl,
                       input logic rdy, input logic ev, input logic [15:0] ed,
                       input logic cd, input string name);
    @(negedge clk);
    rx_valid2 = rv;
    din2      = {op, pl};
    tx_ready2 = rdy;
    @(posedge clk);
    #1;
    check({name, " tx_valid"}, {15'd0, tx_valid2}, {15'd0, ev});
    if (cd) check({name, " dout"}, dout2, ed);
    check({name, " err"}, {15'd0, err2}, 16'd0);
  endtask

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    din       = '0;
    rx_valid  = 1'b0;
    tx_ready  = 1'b0;
    din2      = '0;
    rx_valid2 = 1'b0;
    tx_ready2 = 1'b0;

    //                 rst rv  op     pl     rdy  ev  cd  ed     ee
    // reset state
    vecs.push_back(mk(1, 0, 2'b00, 8'h00, 0,   0,  1, 8'h00, 0)); // 0
    // basic write/read of 0xA5 at 0x10
    vecs.push_back(mk(0, 1, 2'b00, 8'h10, 1,   0,  0, 8'h00, 0));
    vecs.push_back(mk(0, 1, 2'b01, 8'hA5, 1,   0,  0, 8'h00, 0));
    vecs.push_back(mk(0, 1, 2'b10, 8'h10, 1,   0,  0, 8'h00, 0));
    vecs.push_back(mk(0, 1, 2'b11, 8'h00, 1,   1,  1, 8'hA5, 0));
    vecs.push_back(mk(0, 0, 2'b00, 8'h00, 1,   0,  0, 8'h00, 0)); // 5
    // write across the FF->00 wrap, then read back-to-back across it
    vecs.push_back(mk(0, 1, 2'b00, 8'hFE, 1,   0,  0, 8'h00, 0));
    vecs.push_back(mk(0, 1, 2'b01, 8'h11, 1,   0,  0, 8'h00, 0));
    vecs.push_back(mk(0, 1, 2'b01, 8'h22, 1,   0,  0, 8'h00, 0));
    vecs.push_back(mk(0, 1, 2'b01, 8'h33, 1,   0,  0, 8'h00, 0));
    vecs.push_back(mk(0, 1, 2'b10, 8'hFE, 1,   0,  0, 8'h00, 0)); // 10
    vecs.push_back(mk(0, 1, 2'b11, 8'h00, 1,   1,  1, 8'h11, 0));
    vecs.push_back(mk(0, 1, 2'b11, 8'h5C, 1,   1,  1, 8'h22, 0)); // payload ignored
    vecs.push_back(mk(0, 1, 2'b11, 8'h00, 1,   1,  1, 8'h33, 0));
    vecs.push_back(mk(0, 0, 2'b00, 8'h00, 1,   0,  0, 8'h00, 0));
    // backpressure: second read dropped, rd_addr advanced once only
    vecs.push_back(mk(0, 1, 2'b00, 8'h20, 1,   0,  0, 8'h00, 0)); // 15
    vecs.push_back(mk(0, 1, 2'b01, 8'hC1, 1,   0,  0, 8'h00, 0));
    vecs.push_back(mk(0, 1, 2'b01, 8'hC2, 1,   0,  0, 8'h00, 0));
    vecs.push_back(mk(0, 1, 2'b01, 8'hC3, 1,   0,  0, 8'h00, 0));
    vecs.push_back(mk(0, 1, 2'b10, 8'h20, 1,   0,  0, 8'h00, 0));
    vecs.push_back(mk(0, 1, 2'b11, 8'h00, 0,   1,  1, 8'hC1, 0)); // 20
    vecs.push_back(mk(0, 1, 2'b11, 8'h00, 0,   1,  1, 8'hC1, 1));
    vecs.push_back(mk(0, 0, 2'b00, 8'h00, 0,   1,  1, 8'hC1, 1));
    vecs.push_back(mk(0, 1, 2'b11, 8'h00, 1,   1,  1, 8'hC2, 1));
    vecs.push_back(mk(0, 0, 2'b00, 8'h00, 1,   0,  0, 8'h00, 1));
    // write then read same address on the next cycle
    vecs.push_back(mk(0, 1, 2'b00, 8'h40, 1,   0,  0, 8'h00, 1)); // 25
    vecs.push_back(mk(0, 1, 2'b10, 8'h40, 1,   0,  0, 8'h00, 1));
    vecs.push_back(mk(0, 1, 2'b01, 8'h5A, 1,   0,  0, 8'h00, 1));
    vecs.push_back(mk(0, 1, 2'b11, 8'h00, 1,   1,  1, 8'h5A, 1));
    // non-read commands while FULL leave the output alone but still execute
    vecs.push_back(mk(0, 1, 2'b10, 8'h20, 0,   1,  1, 8'h5A, 1));
    vecs.push_back(mk(0, 1, 2'b01, 8'h77, 0,   1,  1, 8'h5A, 1)); // 30
    vecs.push_back(mk(0, 1, 2'b11, 8'h00, 1,   1,  1, 8'hC1, 1));
    // reset while FULL with a read and tx_ready present: reset wins
    vecs.push_back(mk(1, 1, 2'b11, 8'h00, 1,   0,  1, 8'h00, 0));
    vecs.push_back(mk(0, 1, 2'b10, 8'h10, 1,   0,  1, 8'h00, 0));
    vecs.push_back(mk(0, 1, 2'b11, 8'h00, 1,   1,  1, 8'hA5, 0));
    vecs.push_back(mk(0, 0, 2'b00, 8'h00, 1,   0,  0, 8'h00, 0)); // 35
    // rx_valid=0 ignores din completely
    vecs.push_back(mk(0, 1, 2'b00, 8'h30, 1,   0,  0, 8'h00, 0));
    vecs.push_back(mk(0, 0, 2'b01, 8'h99, 1,   0,  0, 8'h00, 0));
    vecs.push_back(mk(0, 1, 2'b01, 8'h66, 1,   0,  0, 8'h00, 0));
    vecs.push_back(mk(0, 1, 2'b10, 8'h30, 1,   0,  0, 8'h00, 0));
    vecs.push_back(mk(0, 1, 2'b11, 8'h00, 1,   1,  1, 8'h66, 0)); // 40
    vecs.push_back(mk(0, 0, 2'b11, 8'h00, 1,   0,  0, 8'h00, 0));

    foreach (vecs[i]) begin
      @(negedge clk);
      rst      = vecs[i].rst;
      rx_valid = vecs[i].rv;
      din      = {vecs[i].op, vecs[i].pl};
      tx_ready = vecs[i].rdy;
      @(posedge clk);
      #1;
      check($sformatf("v%0d tx_valid", i), {15'd0, tx_valid}, {15'd0, vecs[i].ev});
      check($sformatf("v%0d err", i), {15'd0, err}, {15'd0, vecs[i].ee});
      if (vecs[i].cd) check($sformatf("v%0d dout", i), {8'd0, dout}, {8'd0, vecs[i].ed});
    end

    @(negedge clk);
    rst      = 1'b0;
    rx_valid = 1'b0;
    tx_ready = 1'b0;

    // Wide-data, 4-bit-address instance with static addresses.
    step2(1, 2'b00, 16'h000F, 1, 0, 16'h0000, 0, "w16 wr_addr");
    step2(1, 2'b01, 16'hBEEF, 1, 0, 16'h0000, 0, "w16 wr_data");
    step2(1, 2'b10, 16'h001F, 1, 0, 16'h0000, 0, "w16 rd_addr");
    step2(1, 2'b11, 16'h0000, 1, 1, 16'hBEEF, 1, "w16 read1");
    step2(1, 2'b11, 16'h0000, 1, 1, 16'hBEEF, 1, "w16 read2 no inc");
    step2(1, 2'b01, 16'h1234, 1, 0, 16'h0000, 0, "w16 overwrite");
    step2(1, 2'b11, 16'h0000, 1, 1, 16'h1234, 1, "w16 read3");
    step2(0, 2'b00, 16'h0000, 1, 0, 16'h0000, 0, "w16 drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
